// File: rtl/mxv_lane_datapath.sv
// MxV lane datapath: the responder end of the MxV control strobes.
// Two banks of LANES matrix-row FIFOs plus a shared vector buffer feed
// LANES multiply-accumulate lanes. Each pop fetches one operand set and each
// operation consumes it. Two consecutive idle cycles after accumulation
// close the pass and emit one result beat tagged with its bank.
module mxv_lane_datapath #(
  parameter int DW    = 8,
  parameter int LANES = 4,
  parameter int DEPTH = 8,
  parameter int AW    = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [3:0]          wr_target,
  input  logic [DW-1:0]       wr_data,
  input  logic                vec_clr,
  input  logic                sys_reset,
  input  logic                reset_ope,
  input  logic                pop,
  input  logic                operation,
  input  logic                fifo,
  input  logic                err_clr,
  output logic                res_valid,
  output logic                res_bank,
  output logic [LANES*AW-1:0] res_data,
  output logic [2:0]          err
);

  localparam int NF = 2 * LANES;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Multiply-accumulate with modulo-2^AW wrap.
  function automatic logic [AW-1:0] mac_wrap(input logic [AW-1:0] acc,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] x);
    logic [2*DW-1:0] prod;
    prod = a * x;
    return acc + AW'(prod);
  endfunction

  // Storage (data only, never reset)
  logic [DW-1:0]       fifo_mem_q [NF][DEPTH];
  logic [DW-1:0]       vec_mem_q  [DEPTH];

  // FIFO bookkeeping
  logic [PW-1:0]       wptr_q [NF];
  logic [PW-1:0]       wptr_d [NF];
  logic [PW-1:0]       rptr_q [NF];
  logic [PW-1:0]       rptr_d [NF];
  logic [CW-1:0]       cnt_q  [NF];
  logic [CW-1:0]       cnt_d  [NF];
  logic [NF-1:0]       fifo_we;
  logic [NF-1:0]       fifo_take;

  // Vector buffer bookkeeping
  logic [CW-1:0]       vec_cnt_q, vec_cnt_d;
  logic [CW-1:0]       xidx_q, xidx_d;
  logic                vec_we;

  // Operands and accumulators
  logic [DW-1:0]       a_reg_q [LANES];
  logic [DW-1:0]       a_reg_d [LANES];
  logic [DW-1:0]       x_reg_q, x_reg_d;
  logic                opv_q, opv_d;
  logic                op_bank_q, op_bank_d;
  logic                last_bank_q, last_bank_d;
  logic                dirty_q, dirty_d;
  logic [AW-1:0]       acc_q [LANES];
  logic [AW-1:0]       acc_d [LANES];
  logic [1:0]          idle_q, idle_d;

  // Result and error registers
  logic                res_valid_q, res_valid_d;
  logic                res_bank_q, res_bank_d;
  logic [LANES*AW-1:0] res_data_q, res_data_d;
  logic [2:0]          err_q, err_d;

  // Qualified strobes
  logic                pop_eff;
  logic                op_eff;
  logic                idle;
  logic                capture;
  logic                err_ovf, err_unf, err_ovr;

  // Next-state computation for FIFOs, operands, accumulators, pass detection and errors.
  always_comb begin
    pop_eff = pop && !sys_reset && !reset_ope;
    op_eff  = operation && !sys_reset && opv_q;
    idle    = !pop && !operation && !sys_reset && !reset_ope;
    err_ovf = 1'b0;
    err_unf = 1'b0;
    err_ovr = 1'b0;
    fifo_we   = '0;
    fifo_take = '0;

    // Matrix FIFOs: a same-cycle pop frees the slot a write to a full FIFO needs.
    for (int i = 0; i < NF; i++) begin
      wptr_d[i] = wptr_q[i];
      rptr_d[i] = rptr_q[i];
      cnt_d[i]  = cnt_q[i];
      fifo_take[i] = pop_eff && (fifo == (i >= LANES)) && (cnt_q[i] != '0);
      if (wr_en && (int'(wr_target) == i)) begin
        if ((cnt_q[i] < CW'(DEPTH)) || fifo_take[i]) begin
          fifo_we[i] = 1'b1;
        end else begin
          err_ovf = 1'b1;
        end
      end
      if (fifo_we[i]) wptr_d[i] = wptr_q[i] + PW'(1);
      if (fifo_take[i]) rptr_d[i] = rptr_q[i] + PW'(1);
      if (fifo_we[i] && !fifo_take[i]) cnt_d[i] = cnt_q[i] + CW'(1);
      else if (!fifo_we[i] && fifo_take[i]) cnt_d[i] = cnt_q[i] - CW'(1);
    end

    // Vector buffer: clear beats a same-cycle write.
    vec_cnt_d = vec_cnt_q;
    vec_we    = 1'b0;
    if (vec_clr) begin
      vec_cnt_d = '0;
    end else if (wr_en && (int'(wr_target) == NF)) begin
      if (vec_cnt_q < CW'(DEPTH)) begin
        vec_we    = 1'b1;
        vec_cnt_d = vec_cnt_q + CW'(1);
      end else begin
        err_ovf = 1'b1;
      end
    end

    // Operand fetch: empty sources deliver zero and flag underflow.
    for (int k = 0; k < LANES; k++) a_reg_d[k] = a_reg_q[k];
    x_reg_d   = x_reg_q;
    xidx_d    = xidx_q;
    op_bank_d = op_bank_q;
    if (pop_eff) begin
      op_bank_d = fifo;
      for (int k = 0; k < LANES; k++) begin
        if (fifo_take[fifo ? LANES + k : k]) begin
          a_reg_d[k] = fifo ? fifo_mem_q[LANES+k][rptr_q[LANES+k]]
                            : fifo_mem_q[k][rptr_q[k]];
        end else begin
          a_reg_d[k] = '0;
          err_unf    = 1'b1;
        end
      end
      if (xidx_q < vec_cnt_q) begin
        x_reg_d = vec_mem_q[xidx_q[PW-1:0]];
      end else begin
        x_reg_d = '0;
        err_unf = 1'b1;
      end
      if (xidx_q < CW'(DEPTH)) xidx_d = xidx_q + CW'(1);
      if (opv_q && !operation) err_ovr = 1'b1;
    end
    if (sys_reset) xidx_d = '0;

    // Accumulate only when a fresh operand set is pending.
    for (int k = 0; k < LANES; k++) begin
      acc_d[k] = acc_q[k];
      if (op_eff) acc_d[k] = mac_wrap(acc_q[k], a_reg_q[k], x_reg_q);
      if (sys_reset) acc_d[k] = '0;
    end

    if (sys_reset || reset_ope) opv_d = 1'b0;
    else if (pop_eff)           opv_d = 1'b1;
    else if (op_eff)            opv_d = 1'b0;
    else                        opv_d = opv_q;

    last_bank_d = op_eff ? op_bank_q : last_bank_q;

    // Pass completion: second consecutive idle cycle with pending accumulation.
    idle_d  = idle ? ((idle_q == 2'd3) ? 2'd3 : idle_q + 2'd1) : 2'd0;
    capture = dirty_q && idle && (idle_q == 2'd1);

    if (sys_reset)    dirty_d = 1'b0;
    else if (op_eff)  dirty_d = 1'b1;
    else if (capture) dirty_d = 1'b0;
    else              dirty_d = dirty_q;

    res_valid_d = capture;
    res_bank_d  = capture ? last_bank_q : res_bank_q;
    res_data_d  = res_data_q;
    if (capture) begin
      for (int k = 0; k < LANES; k++) res_data_d[k*AW +: AW] = acc_q[k];
    end

    // New errors win over a same-cycle clear.
    err_d = (err_clr ? 3'b000 : err_q) | {err_ovr, err_unf, err_ovf};
  end

  // Storage writes; contents need no reset since pointers and counts gate every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NF; i++) begin
      if (fifo_we[i]) fifo_mem_q[i][wptr_q[i]] <= wr_data;
    end
    if (vec_we) vec_mem_q[vec_cnt_q[PW-1:0]] <= wr_data;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NF; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      for (int k = 0; k < LANES; k++) begin
        a_reg_q[k] <= '0;
        acc_q[k]   <= '0;
      end
      vec_cnt_q   <= '0;
      xidx_q      <= '0;
      x_reg_q     <= '0;
      opv_q       <= 1'b0;
      op_bank_q   <= 1'b0;
      last_bank_q <= 1'b0;
      dirty_q     <= 1'b0;
      idle_q      <= 2'd0;
      res_valid_q <= 1'b0;
      res_bank_q  <= 1'b0;
      res_data_q  <= '0;
      err_q       <= 3'b000;
    end else begin
      for (int i = 0; i < NF; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      for (int k = 0; k < LANES; k++) begin
        a_reg_q[k] <= a_reg_d[k];
        acc_q[k]   <= acc_d[k];
      end
      vec_cnt_q   <= vec_cnt_d;
      xidx_q      <= xidx_d;
      x_reg_q     <= x_reg_d;
      opv_q       <= opv_d;
      op_bank_q   <= op_bank_d;
      last_bank_q <= last_bank_d;
      dirty_q     <= dirty_d;
      idle_q      <= idle_d;
      res_valid_q <= res_valid_d;
      res_bank_q  <= res_bank_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_bank  = res_bank_q;
  assign res_data  = res_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mxv_lane_datapath.sv
// Scoreboard bench for mxv_lane_datapath: expected result beats are queued
// as each pass is driven and compared when res_valid appears.
module tb_mxv_lane_datapath;

  localparam int DW    = 8;
  localparam int LANES = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 20;
  localparam int RW    = LANES * AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [3:0]    wr_target;
  logic [DW-1:0] wr_data;
  logic          vec_clr, sys_reset, reset_ope, pop, operation, fifo, err_clr;
  logic          res_valid, res_bank;
  logic [RW-1:0] res_data;
  logic [2:0]    err;

  typedef struct {
    logic          bank;
    logic [RW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   res_cnt  = 0;

  mxv_lane_datapath #(.DW(DW), .LANES(LANES), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_target(wr_target),
    .wr_data(wr_data), .vec_clr(vec_clr), .sys_reset(sys_reset),
    .reset_ope(reset_ope), .pop(pop), .operation(operation), .fifo(fifo),
    .err_clr(err_clr), .res_valid(res_valid), .res_bank(res_bank),
    .res_data(res_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
    logic [RW-1:0] v;
    v = '0;
    v[0*AW +: AW] = AW'(l0);
    v[1*AW +: AW] = AW'(l1);
    v[2*AW +: AW] = AW'(l2);
    v[3*AW +: AW] = AW'(l3);
    return v;
  endfunction

  task automatic push_exp(input logic b, input logic [RW-1:0] d);
    exp_t e;
    e.bank = b;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Result monitor: every beat must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && res_valid) begin
      res_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_res", RW'(1), RW'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_bank", RW'(res_bank), RW'(e.bank));
        for (int k = 0; k < LANES; k++)
          chk($sformatf("res_lane%0d", k), RW'(res_data[k*AW +: AW]), RW'(e.data[k*AW +: AW]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int tgt, input int d);
    wr_en = 1'b1; wr_target = 4'(tgt); wr_data = DW'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic strobe(input logic p, input logic o, input logic f);
    pop = p; operation = o; fifo = f;
    tick();
    pop = 1'b0; operation = 1'b0;
  endtask

  task automatic pulse_sysrst();
    sys_reset = 1'b1; tick(); sys_reset = 1'b0;
  endtask

  task automatic pulse_errclr();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
  endtask

  task automatic pulse_vecclr();
    vec_clr = 1'b1; tick(); vec_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_target = '0; wr_data = '0;
    vec_clr = 1'b0; sys_reset = 1'b0; reset_ope = 1'b0;
    pop = 1'b0; operation = 1'b0; fifo = 1'b0; err_clr = 1'b0;
    idle(3);
    chk("rst_res_valid", RW'(res_valid), RW'(0));
    chk("rst_res_bank", RW'(res_bank), RW'(0));
    chk("rst_res_data", res_data, RW'(0));
    chk("rst_err", RW'(err), RW'(0));
    reset = 1'b1;
    tick();

    // Pass 1: bank0 rows {1,2},{3,4},{5,6},{7,8}, vector {10,20}
    for (int k = 0; k < LANES; k++) begin
      wr(k, 2*k + 1);
      wr(k, 2*k + 2);
    end
    wr(2*LANES, 10);
    wr(2*LANES, 20);
    pulse_sysrst();
    push_exp(1'b0, pack4(50, 110, 170, 230));
    strobe(1, 0, 0); strobe(0, 1, 0);
    strobe(1, 0, 0); strobe(0, 1, 0);
    idle(3);
    chk("p1_res_count", RW'(res_cnt), RW'(1));
    idle(3);
    chk("p1_no_repeat", RW'(res_cnt), RW'(1));
    chk("p1_err", RW'(err), RW'(0));

    // Pass 2: bank1 rows all {1,1}, same vector
    for (int k = 0; k < LANES; k++) begin
      wr(LANES + k, 1);
      wr(LANES + k, 1);
    end
    pulse_sysrst();
    push_exp(1'b1, pack4(30, 30, 30, 30));
    strobe(1, 0, 1); strobe(0, 1, 1);
    strobe(1, 0, 1); strobe(0, 1, 1);
    idle(3);
    chk("p2_res_count", RW'(res_cnt), RW'(2));
    chk("p2_hold_data", res_data, pack4(30, 30, 30, 30));
    chk("p2_hold_bank", RW'(res_bank), RW'(1));
    chk("p2_err", RW'(err), RW'(0));

    // Pass 3: repeated operation without a new pop counts once
    for (int k = 0; k < LANES; k++) wr(k, k + 3);
    pulse_vecclr();
    wr(2*LANES, 7);
    pulse_sysrst();
    push_exp(1'b0, pack4(21, 28, 35, 42));
    strobe(1, 0, 0);
    strobe(0, 1, 0); strobe(0, 1, 0); strobe(0, 1, 0);
    idle(3);
    chk("p3_res_count", RW'(res_cnt), RW'(3));
    chk("p3_err", RW'(err), RW'(0));

    // Underflow: empty bank0 lanes and empty vector
    pulse_vecclr();
    pulse_sysrst();
    strobe(1, 0, 0);
    chk("unf_set", RW'(err), RW'(3'b010));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("unf_hold", RW'(err), RW'(3'b010));
    end
    pulse_errclr();
    chk("unf_clr", RW'(err), RW'(0));
    chk("unf_no_res", RW'(res_cnt), RW'(3));

    // Overflow: nine writes to a depth-8 FIFO, then write+pop while full
    pulse_sysrst();
    for (int k = 1; k < LANES; k++) wr(k, k + 1);
    wr(2*LANES, 5);
    for (int i = 1; i <= DEPTH; i++) wr(0, i);
    chk("ovf_before_full", RW'(err), RW'(0));
    wr(0, 9);
    chk("ovf_set", RW'(err), RW'(3'b001));
    pulse_errclr();
    chk("ovf_clr", RW'(err), RW'(0));
    wr_en = 1'b1; wr_target = 4'd0; wr_data = DW'(100);
    pop = 1'b1; fifo = 1'b0;
    tick();
    wr_en = 1'b0; pop = 1'b0;
    chk("full_wr_pop_err", RW'(err), RW'(0));
    push_exp(1'b0, pack4(5, 10, 15, 20));
    strobe(0, 1, 0);
    idle(3);
    chk("ovf_res_count", RW'(res_cnt), RW'(4));
    wr(0, 55);
    chk("full_count_kept", RW'(err), RW'(3'b001));
    pulse_errclr();

    // Overrun, then asynchronous reset in the middle of a pass
    pulse_sysrst();
    pulse_errclr();
    strobe(1, 0, 0);
    chk("ovr_first_pop", RW'(err[2]), RW'(0));
    strobe(1, 0, 0);
    chk("ovr_set", RW'(err[2]), RW'(1));
    strobe(0, 1, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("async_rst_data", res_data, RW'(0));
    chk("async_rst_err", RW'(err), RW'(0));
    idle(2);
    reset = 1'b1;
    idle(4);
    chk("abort_res_count", RW'(res_cnt), RW'(4));
    chk("abort_res_valid", RW'(res_valid), RW'(0));
    chk("abort_res_bank", RW'(res_bank), RW'(0));
    chk("abort_res_data", res_data, RW'(0));
    chk("abort_err", RW'(err), RW'(0));
    chk("scoreboard_drained", RW'(exp_q.size()), RW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
